// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO pointer logic: Gray/binary conversion
// and the MSB-inverted Gray compare used for full (write side) detection.
// Pointers are handled as zero-extended 32-bit words plus an explicit width,
// so one set of functions serves every pointer width up to 32 bits.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int PTR_MAX_W     = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  // Mask keeping the low 'width' bits of a pointer word.
  function automatic ptr_word_t ptr_mask(input int width);
    ptr_word_t m;
    if (width >= PTR_MAX_W) m = '1;
    else                    m = (ptr_word_t'(1) << width) - ptr_word_t'(1);
    return m;
  endfunction

  // Binary to Gray: each Gray bit is the XOR of adjacent binary bits.
  function automatic ptr_word_t bin2gray(input ptr_word_t bin, input int width);
    ptr_word_t b;
    b = bin & ptr_mask(width);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: binary bit i is the XOR-reduction of Gray bits i and up.
  function automatic ptr_word_t gray2bin(input ptr_word_t gray, input int width);
    ptr_word_t g;
    ptr_word_t b;
    g = gray & ptr_mask(width);
    b = '0;
    for (int i = 0; i < PTR_MAX_W; i++) begin
      if (i < width) b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // True when two Gray pointers are exactly one lap apart: the top two bits
  // differ and every lower bit matches.
  function automatic logic gray_full_match(input ptr_word_t a_gray,
                                           input ptr_word_t b_gray,
                                           input int        width);
    ptr_word_t top2;
    top2 = ptr_word_t'(3) << (width - 2);
    return ((a_gray ^ b_gray) & ptr_mask(width)) == top2;
  endfunction

endpackage

// File: rtl/fifo_sync_ptr.sv
// Multi-flop synchronizer for a Gray-coded pointer crossing clock domains.
// Pure flop chain: no logic between stages, so each stage has a full cycle
// to resolve metastability. Used for rptr->wclk and wptr->rclk alike.
module fifo_sync_ptr
  import fifo_pkg::*;
#(
  parameter int WIDTH       = FIFO_ADDRSIZE + 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // Shift the asynchronous pointer through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= d;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side controller of the async FIFO (wclk domain).
// Keeps the binary/Gray write pointers, synchronizes the read Gray pointer,
// and produces registered full, almost-full, occupancy and sticky overflow.
//
// Write handshake: winc is a per-cycle request; wclken is the grant. A write
// happens on a wclk edge exactly when wclken=1 (winc=1 and not full). A
// request while full is dropped, leaves the pointer untouched and sets
// woverflow. There is no backpressure beyond wfull itself.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE     = FIFO_ADDRSIZE,
  parameter int AFULL_THRESH = 12,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic                wclr_ovf,
  input  logic [ADDRSIZE:0]   rptr_gray,
  output logic [ADDRSIZE:0]   wptr_gray,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wcount,
  output logic                woverflow
);

  localparam int               PTR_W     = ADDRSIZE + 1;
  localparam logic [PTR_W-1:0] AFULL_VAL = PTR_W'(AFULL_THRESH);

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] wq_rptr;
  logic [PTR_W-1:0] wq_rptr_bin;
  logic [PTR_W-1:0] wcount_next;
  logic             wfull_next;
  logic             walmost_full_next;

  // Read pointer brought into wclk; it lags the true read pointer, which
  // makes full and occupancy conservative.
  fifo_sync_ptr #(
    .WIDTH       (PTR_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_rptr (
    .clk   (wclk),
    .rst_n (wrst_n),
    .d     (rptr_gray),
    .q     (wq_rptr)
  );

  // Grant, next pointer, and next-state flags from the post-write pointer.
  // wclken is also held low while reset is asserted so the memory sees no
  // writes during reset.
  always_comb begin
    wclken            = winc & ~wfull & wrst_n;
    wbin_next         = wbin + {{ADDRSIZE{1'b0}}, wclken};
    wgray_next        = PTR_W'(bin2gray(ptr_word_t'(wbin_next), PTR_W));
    wq_rptr_bin       = PTR_W'(gray2bin(ptr_word_t'(wq_rptr), PTR_W));
    wcount_next       = wbin_next - wq_rptr_bin;
    wfull_next        = gray_full_match(ptr_word_t'(wgray_next),
                                        ptr_word_t'(wq_rptr), PTR_W);
    walmost_full_next = (wcount_next >= AFULL_VAL);
  end

  assign waddr = wbin[ADDRSIZE-1:0];

  // Write pointer registers, binary and Gray, advanced together.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin      <= '0;
      wptr_gray <= '0;
    end else begin
      wbin      <= wbin_next;
      wptr_gray <= wgray_next;
    end
  end

  // Registered status: full, almost-full, occupancy and sticky overflow
  // (a new overflow takes priority over a clear in the same cycle).
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
      woverflow    <= 1'b0;
    end else begin
      wfull        <= wfull_next;
      walmost_full <= walmost_full_next;
      wcount       <= wcount_next;
      woverflow    <= (winc & wfull) | (woverflow & ~wclr_ovf);
    end
  end

endmodule

// File: tb/tb_fifo_wptr_full.sv
// Bench for fifo_wptr_full: fixed vector table for reset/fill/overflow/drain,
// hand sequences for async reset and wrap, then random traffic against an
// integer-count reference model.
`timescale 1ns/1ps
module tb_fifo_wptr_full;

  localparam int ADDRSIZE     = 4;
  localparam int DEPTH        = 16;
  localparam int AFULL_THRESH = 12;
  localparam int SYNC_STAGES  = 2;
  localparam int OUT_W        = 17;
  localparam int NV           = 24;

  logic       wclk = 1'b0;
  logic       wrst_n = 1'b0;
  logic       winc = 1'b0;
  logic       wclr_ovf = 1'b0;
  logic [4:0] rptr_gray = 5'd0;
  logic [4:0] wptr_gray;
  logic [3:0] waddr;
  logic       wclken;
  logic       wfull;
  logic       walmost_full;
  logic [4:0] wcount;
  logic       woverflow;

  fifo_wptr_full #(
    .ADDRSIZE     (ADDRSIZE),
    .AFULL_THRESH (AFULL_THRESH),
    .SYNC_STAGES  (SYNC_STAGES)
  ) dut (
    .wclk         (wclk),
    .wrst_n       (wrst_n),
    .winc         (winc),
    .wclr_ovf     (wclr_ovf),
    .rptr_gray    (rptr_gray),
    .wptr_gray    (wptr_gray),
    .waddr        (waddr),
    .wclken       (wclken),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wcount       (wcount),
    .woverflow    (woverflow)
  );

  // ---------------- clock ----------------
  always #5 wclk = ~wclk;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [OUT_W-1:0] exp_q[$];

  typedef struct {
    bit               winc;
    bit               clr;
    logic [4:0]       rptr;
    bit               exp_en;
    logic [OUT_W-1:0] exp_v;
  } vec_t;

  vec_t vecs[NV];

  // Reference model: unbounded write/read counts, read count seen through
  // a SYNC_STAGES-deep delay queue.
  int m_wr;
  bit m_full;
  bit m_ovf;
  int m_rd_hist[$];

  function automatic logic [4:0] g5(input int b);
    int m;
    m = b % 32;
    return 5'(m ^ (m >> 1));
  endfunction

  function automatic logic [OUT_W-1:0] pack(input logic [4:0] g, input logic [3:0] a,
                                            input bit f, input bit af,
                                            input logic [4:0] c, input bit o);
    return {g, a, f, af, c, o};
  endfunction

  function automatic logic [OUT_W-1:0] dut_vec();
    return {wptr_gray, waddr, wfull, walmost_full, wcount, woverflow};
  endfunction

  function automatic vec_t mk(input bit inc, input bit clr, input int rp, input bit en,
                              input int g, input int a, input bit f, input bit af,
                              input int c, input bit o);
    vec_t v;
    v.winc   = inc;
    v.clr    = clr;
    v.rptr   = 5'(rp);
    v.exp_en = en;
    v.exp_v  = pack(5'(g), 4'(a), f, af, 5'(c), o);
    return v;
  endfunction

  task automatic check(input string name, input logic [OUT_W-1:0] got,
                       input logic [OUT_W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_check(input string name, input bit inc, input bit clr,
                             input logic [4:0] rp, input bit exp_en,
                             input logic [OUT_W-1:0] exp_v);
    @(negedge wclk);
    winc      = inc;
    wclr_ovf  = clr;
    rptr_gray = rp;
    #1;
    check({name, ".wclken"}, OUT_W'(wclken), OUT_W'(exp_en));
    exp_q.push_back(exp_v);
    @(posedge wclk);
    #1;
    check({name, ".outs"}, dut_vec(), exp_q.pop_front());
  endtask

  task automatic apply_vecs(input string name, input int first, input int last);
    for (int i = first; i <= last; i++)
      drive_check($sformatf("%s[%0d]", name, i), vecs[i].winc, vecs[i].clr,
                  vecs[i].rptr, vecs[i].exp_en, vecs[i].exp_v);
  endtask

  task automatic model_step(input string name, input bit inc, input bit clr, input int rd);
    bit acc;
    bit ovf_n;
    int r_used;
    int occ;
    acc   = inc && !m_full;
    ovf_n = (inc && m_full) || (m_ovf && !clr);
    if (acc) m_wr++;
    r_used = m_rd_hist.pop_front();
    m_rd_hist.push_back(rd);
    occ    = m_wr - r_used;
    m_full = (occ == DEPTH);
    m_ovf  = ovf_n;
    drive_check(name, inc, clr, g5(rd), acc,
                pack(g5(m_wr), 4'(m_wr % DEPTH), m_full, occ >= AFULL_THRESH,
                     5'(occ), m_ovf));
  endtask

  task automatic do_reset();
    @(negedge wclk);
    wrst_n    = 1'b0;
    wclr_ovf  = 1'b0;
    rptr_gray = 5'd0;
    for (int i = 0; i < 4; i++) begin
      winc = i[0];
      #1;
      check("rst.wclken", OUT_W'(wclken), '0);
      check("rst.outs", dut_vec(), '0);
      @(negedge wclk);
    end
    wrst_n = 1'b1;
    winc   = 1'b0;
    m_wr   = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_rd_hist.delete();
    repeat (SYNC_STAGES) m_rd_hist.push_back(0);
  endtask

  task automatic run_wrap();
    int         wr_hist[$];
    logic [4:0] prev_g;
    int         rd;
    int         guard;
    prev_g = 5'd0;
    guard  = 0;
    while (m_wr < 40 && guard < 80) begin
      rd = (wr_hist.size() >= 4) ? wr_hist[wr_hist.size()-4] : 0;
      model_step("wrap", 1'b1, 1'b0, rd);
      wr_hist.push_back(m_wr);
      if (wptr_gray != prev_g)
        check("wrap.onebit", OUT_W'($countones(wptr_gray ^ prev_g)), OUT_W'(1));
      check("wrap.nofull", OUT_W'(wfull), '0);
      if (m_wr == 15) check("wrap.msb15", OUT_W'(wptr_gray[4]), OUT_W'(0));
      if (m_wr == 16) check("wrap.msb16", OUT_W'(wptr_gray[4]), OUT_W'(1));
      if (m_wr == 32) check("wrap.msb32", OUT_W'(wptr_gray[4]), OUT_W'(0));
      prev_g = wptr_gray;
      guard++;
    end
    check("wrap.budget", OUT_W'(guard < 80), OUT_W'(1));
  endtask

  task automatic run_random(input int cycles);
    int rd;
    int wp;
    int rp;
    bit inc;
    bit clr;
    rd = 0;
    for (int c = 0; c < cycles; c++) begin
      wp  = ((c / 100) % 2 == 1) ? 40 : 90;
      rp  = ((c / 100) % 2 == 1) ? 85 : 25;
      inc = ($urandom_range(0, 99) < wp);
      clr = ($urandom_range(0, 15) == 0);
      if (rd < m_wr && $urandom_range(0, 99) < rp) rd++;
      model_step("rand", inc, clr, rd);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    // Fill from empty: entry i is the (i+1)-th accepted write.
    for (int i = 0; i < 16; i++)
      vecs[i] = mk(1, 0, 0, 1, int'(g5(i + 1)), (i + 1) % 16, i == 15,
                   (i + 1) >= AFULL_THRESH, i + 1, 0);
    // Overflow while full, clear, set-and-clear together.
    vecs[16] = mk(1, 0, 0, 0, 24, 0, 1, 1, 16, 1);
    vecs[17] = mk(1, 0, 0, 0, 24, 0, 1, 1, 16, 1);
    vecs[18] = mk(0, 1, 0, 0, 24, 0, 1, 1, 16, 0);
    vecs[19] = mk(1, 1, 0, 0, 24, 0, 1, 1, 16, 1);
    // Read pointer advances by one: full drops on the third edge.
    vecs[20] = mk(0, 0, 1, 0, 24, 0, 1, 1, 16, 1);
    vecs[21] = mk(0, 0, 1, 0, 24, 0, 1, 1, 16, 1);
    vecs[22] = mk(0, 0, 1, 0, 24, 0, 0, 1, 15, 1);
    vecs[23] = mk(1, 0, 1, 1, 25, 1, 1, 1, 16, 1);

    do_reset();
    apply_vecs("fill", 0, NV - 1);

    // Reset in the middle of a fill, asserted between clock edges.
    do_reset();
    apply_vecs("pre_rst", 0, 8);
    @(negedge wclk);
    #2;
    wrst_n = 1'b0;
    #1;
    check("async_rst.outs", dut_vec(), '0);
    check("async_rst.wclken", OUT_W'(wclken), '0);
    do_reset();
    apply_vecs("refill", 0, 15);

    do_reset();
    run_wrap();

    do_reset();
    run_random(600);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
